// File: rtl/btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_pulse
// Purpose  : Push-button conditioning for the safe front panel. Each channel
//            is synchronised to clk through two flops, debounced with a
//            stability counter, and turned into a clean level plus one-cycle
//            press, release and long-press strobes.
// Ports    : clk           system clock
//            rst           asynchronous active-high reset
//            btn_raw       raw active-high button pins, asynchronous to clk
//            btn_level     debounced button state
//            press_pulse   one-cycle strobe on an accepted press
//            release_pulse one-cycle strobe on an accepted release
//            long_pulse    one-cycle strobe, LONG_CYCLES into a hold
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce_pulse #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 200000000,
    parameter int CNT_W           = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse
);

    localparam logic [1:0] c_IDLE         = 2'd0;
    localparam logic [1:0] c_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_HELD         = 2'd2;
    localparam logic [1:0] c_RELEASE_WAIT = 2'd3;

    // Terminal counts. Debounce windows end on the last count so the counter
    // never wraps; the hold counter parks at LONG_CYCLES so the long strobe
    // cannot recur within a single hold.
    localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LONG_SAT  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            logic             r_sync1;
            logic             r_sync2;
            logic [1:0]       r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;
            logic             r_press;
            logic             r_release;
            logic             r_long;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_state   <= c_IDLE;
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_long    <= 1'b0;
                end else begin
                    r_sync1   <= btn_raw[gi];
                    r_sync2   <= r_sync1;
                    // Strobes default low so each is exactly one cycle wide.
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_long    <= 1'b0;

                    case (r_state)
                        c_IDLE: begin
                            if (r_sync2) begin
                                r_state <= c_PRESS_WAIT;
                                r_cnt   <= '0;
                            end
                        end

                        c_PRESS_WAIT: begin
                            if (!r_sync2) begin
                                r_state <= c_IDLE;
                            end else if (r_cnt == c_DEB_LAST) begin
                                r_state <= c_HELD;
                                r_level <= 1'b1;
                                r_press <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end

                        c_HELD: begin
                            if (!r_sync2) begin
                                r_state <= c_RELEASE_WAIT;
                                r_cnt   <= '0;
                            end else begin
                                if (r_cnt == c_LONG_LAST) begin
                                    r_long <= 1'b1;
                                end
                                if (r_cnt != c_LONG_SAT) begin
                                    r_cnt <= r_cnt + c_ONE;
                                end
                            end
                        end

                        c_RELEASE_WAIT: begin
                            if (r_sync2) begin
                                // Release glitch: stay pressed, restart the
                                // long-press timing.
                                r_state <= c_HELD;
                                r_cnt   <= '0;
                            end else if (r_cnt == c_DEB_LAST) begin
                                r_state   <= c_IDLE;
                                r_level   <= 1'b0;
                                r_release <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end

                        default: begin
                            r_state <= c_IDLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end

            assign btn_level[gi]     = r_level;
            assign press_pulse[gi]   = r_press;
            assign release_pulse[gi] = r_release;
            assign long_pulse[gi]    = r_long;
        end
    endgenerate

endmodule
`default_nettype wire
